// File: rtl/sqrt_nr_seq.sv
// Sequential non-restoring integer square root: one root bit per clock, start/done handshake.
// Define SQRT_ROUND_EN to add a ROUND state that makes root round-to-nearest (saturating).
module sqrt_nr_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   number,
    output logic           busy,
    output logic           done,
    output logic [N/2-1:0] root,
    output logic [N/2:0]   remainder
);

    localparam int H  = N / 2;
    localparam int PW = H + 2;
    localparam int CW = $clog2(H);

`ifdef SQRT_ROUND_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, ROUND} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`endif

    state_t         state_reg, state_next;
    logic [N-1:0]   opnd_reg, opnd_next;
    logic [H-1:0]   q_reg, q_next;
    logic [PW-1:0]  p_reg, p_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [H-1:0]   root_reg, root_next;
    logic [H:0]     rem_reg, rem_next;

    logic [1:0]     pair;
    logic [PW-1:0]  p_shift;
    logic [PW-1:0]  p_step;
    logic [H:0]     p_fix;

    // p is two's complement; shifting in the next radicand pair is a plain bit concat.
    assign pair    = opnd_reg[N-1:N-2];
    assign p_shift = {p_reg[PW-3:0], pair};
    assign p_step  = p_reg[PW-1] ? (p_shift + {q_reg, 2'b11})
                                 : (p_shift - {q_reg, 2'b01});
    // Once corrected the remainder is non-negative and fits in H+1 bits.
    assign p_fix   = p_reg[H:0] + (p_reg[PW-1] ? {q_reg, 1'b1} : {(H+1){1'b0}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            opnd_reg  <= '0;
            q_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            root_reg  <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            opnd_reg  <= opnd_next;
            q_reg     <= q_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            root_reg  <= root_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        opnd_next  = opnd_reg;
        q_next     = q_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        root_next  = root_reg;
        rem_next   = rem_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    opnd_next  = number;
                    q_next     = '0;
                    p_next     = '0;
                    cnt_next   = CW'(H - 1);
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                opnd_next = opnd_reg << 2;
                p_next    = p_step;
                q_next    = {q_reg[H-2:0], ~p_step[PW-1]};
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            FIX: begin
`ifdef SQRT_ROUND_EN
                p_next     = {1'b0, p_fix};
                state_next = ROUND;
`else
                root_next  = q_reg;
                rem_next   = p_fix;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
`endif
            end
`ifdef SQRT_ROUND_EN
            ROUND: begin
                // Round up when remainder > q, i.e. number is past (q + 0.5)^2.
                if ({1'b0, q_reg} < p_reg[H:0]) begin
                    root_next = (&q_reg) ? q_reg : q_reg + 1'b1;
                end else begin
                    root_next = q_reg;
                end
                rem_next   = p_reg[H:0];
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign root      = root_reg;
    assign remainder = rem_reg;

endmodule

// File: tb/tb_sqrt_nr_seq.sv
// Bench for sqrt_nr_seq at N=8/16/32: directed literal cases plus random start/number
// streams checked every cycle against an arithmetic floor-sqrt model.
module tb_sqrt_nr_seq;

`ifdef SQRT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam int LAT32 = ROUND_EN ? 18 : 17;

    logic        clk;
    logic        reset;
    logic        start_a [3];
    logic [31:0] number_a [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic [31:0] root_w [3];
    logic [32:0] rem_w [3];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    bit              pend [3];
    int              pend_edge [3];
    longint unsigned pend_num [3];
    longint unsigned exp_root [3];
    longint unsigned exp_rem [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int NW = 8 << gi;
        logic [NW/2-1:0] r;
        logic [NW/2:0]   rm;
        logic            b;
        logic            d;
        sqrt_nr_seq #(.N(NW)) u_dut (
            .clk(clk),
            .reset(reset),
            .start(start_a[gi]),
            .number(number_a[gi][NW-1:0]),
            .busy(b),
            .done(d),
            .root(r),
            .remainder(rm)
        );
        assign busy_w[gi] = b;
        assign done_w[gi] = d;
        assign root_w[gi] = 32'(r);
        assign rem_w[gi]  = 33'(rm);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", nm, act, want, edge_cnt);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned r = 0;
        longint unsigned t;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    function automatic int lat(input int i);
        return (4 << i) + 1 + int'(ROUND_EN);
    endfunction

    // Model: at most one operation in flight per instance; outputs hold the last result.
    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; pend_edge[i] = 0; pend_num[i] = 0; exp_root[i] = 0; exp_rem[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                bit              ed;
                longint unsigned r, rm, mx;
                if (reset) begin
                    pend[i] = 0; exp_root[i] = 0; exp_rem[i] = 0;
                end
                ed = pend[i] && (pend_edge[i] + lat(i) == edge_cnt);
                chk($sformatf("done[N=%0d]", 8 << i), done_w[i], ed);
                chk($sformatf("busy[N=%0d]", 8 << i), busy_w[i], pend[i] && !ed);
                if (ed) begin
                    r  = isqrt(pend_num[i]);
                    rm = pend_num[i] - r * r;
                    mx = (64'd1 << (4 << i)) - 1;
                    if (ROUND_EN && rm > r) r = (r == mx) ? mx : r + 1;
                    exp_root[i] = r;
                    exp_rem[i]  = rm;
                    pend[i]     = 0;
                end
                chk($sformatf("root[N=%0d]", 8 << i), root_w[i], exp_root[i]);
                chk($sformatf("rem[N=%0d]", 8 << i), rem_w[i], exp_rem[i]);
                if (!reset && start_a[i] && !pend[i]) begin
                    pend[i]      = 1;
                    pend_edge[i] = edge_cnt + 1;
                    pend_num[i]  = longint'(number_a[i]) & ((64'd1 << (8 << i)) - 1);
                end
            end
        end
    end

    task automatic go2(input logic [31:0] num, output int acc);
        @(posedge clk); #2;
        start_a[2]  = 1'b1;
        number_a[2] = num;
        @(posedge clk); #1;
        acc = edge_cnt;
        #1;
        start_a[2]  = 1'b0;
        number_a[2] = $urandom;
    endtask

    task automatic wait_done(input int acc, input longint unsigned er, input longint unsigned erm,
                             input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[2] && n < 60);
        chk({nm, "_latency"}, longint'(edge_cnt - acc), LAT32);
        chk({nm, "_root"}, root_w[2], er);
        chk({nm, "_rem"}, rem_w[2], erm);
    endtask

    function automatic logic [31:0] pick(input int i);
        logic [31:0] full;
        logic [31:0] k;
        int          sel;
        full = (i == 2) ? 32'hFFFF_FFFF : ((32'd1 << (8 << i)) - 1);
        sel  = int'($urandom_range(7));
        k    = $urandom & (full >> (4 << i));
        case (sel)
            0:       return 32'd0;
            1:       return full;
            2:       return k * k;
            3:       return (k * k) - 1;
            default: return $urandom & full;
        endcase
    endfunction

    initial begin
        int acc;
        int acc2;
        int ncyc [3];
        ncyc[0] = 6000; ncyc[1] = 8000; ncyc[2] = 20000;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            number_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy_w[2], 0);
        chk("reset_root", root_w[2], 0);

        go2(32'd144, acc);        wait_done(acc, 12, 0, "sq144");
        go2(32'hFFFF_FFFF, acc);  wait_done(acc, 65535, 131070, "max");
        go2(32'd0, acc);          wait_done(acc, 0, 0, "zero");
        go2(32'd157, acc);        wait_done(acc, ROUND_EN ? 13 : 12, 13, "n157");

        // start held high: the second operand is taken on the edge after done
        @(posedge clk); #2;
        start_a[2] = 1'b1; number_a[2] = 32'd156;
        @(posedge clk); #1;
        acc = edge_cnt;
        #1 number_a[2] = 32'd255;
        wait_done(acc, 12, 12, "b2b_first");
        @(posedge clk); #1;
        acc2 = edge_cnt;
        #1 start_a[2] = 1'b0;
        wait_done(acc2, ROUND_EN ? 16 : 15, 30, "b2b_second");

        // start pulsed mid-RUN must be ignored
        go2(32'd200, acc);
        repeat (5) @(posedge clk);
        #2 start_a[2] = 1'b1; number_a[2] = 32'd50;
        @(posedge clk); #2 start_a[2] = 1'b0;
        wait_done(acc, 14, 4, "ignore_start");

        // asynchronous reset mid-RUN clears everything immediately
        go2(32'd1000, acc);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy_w[2], 0);
        chk("abort_done", done_w[2], 0);
        chk("abort_root", root_w[2], 0);
        chk("abort_rem", rem_w[2], 0);
        @(posedge clk); #2 reset = 1'b0;
        go2(32'd1000, acc);       wait_done(acc, ROUND_EN ? 32 : 31, 39, "after_abort");

        // random start/number streams; the model checks every cycle
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < ncyc[i]; c++) begin
                @(posedge clk); #2;
                start_a[i]  = ($urandom_range(3) != 0);
                number_a[i] = pick(i);
            end
            @(posedge clk); #2 start_a[i] = 1'b0;
            repeat (30) @(posedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
